// File: rtl/pool_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pool_pkg
// Brief    : Shared constants, state encoding and address helper for the
//            layer-1 2x2 max-pool / ceiling stage.
// Revision : 1.0  initial release
// ============================================================================
package pool_pkg;

    // Image geometry: layer-0 is IMG_W x IMG_W and layer-1 is half that size
    localparam int IMG_W  = 64;
    localparam int IMG_AW = $clog2(IMG_W);
    localparam int OUT_W  = IMG_W / 2;
    localparam int OUT_AW = $clog2(OUT_W);
    localparam int O_W    = 2 * OUT_AW;
    localparam int AW     = 2 * IMG_AW;

    // Pixel format: unsigned fixed point with FRAC fraction bits
    localparam int DW   = 13;
    localparam int FRAC = 4;

    // Largest representable integer with a zero fraction
    localparam logic [DW-1:0] SAT_VAL = 13'h1FF0;

    // Index of the last output pixel in raster order
    localparam logic [O_W-1:0] O_LAST = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Read address of tap k in the 2x2 window belonging to output index o.
    // k[1] selects the lower row, k[0] the right column.
    function automatic logic [AW-1:0] rd_addr(input logic [O_W-1:0] o,
                                              input logic [1:0]     k);
        return {o[O_W-1:OUT_AW], k[1], o[OUT_AW-1:0], k[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ceil_q_sat.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ceil_q_sat
// Brief    : Rounds an unsigned fixed-point value up to the next integer and
//            saturates when the integer part is already at its maximum.
// Revision : 1.0  initial release
// ============================================================================
module ceil_q_sat #(
    parameter int              DW   = 13,
    parameter int              FRAC = 4,
    parameter logic [DW-1:0]   SAT  = {{(DW-FRAC){1'b1}}, {FRAC{1'b0}}}
) (
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-FRAC-1:0] w_int;
    logic [DW-FRAC-1:0] w_int_inc;
    logic [FRAC-1:0]    w_frac;

    assign w_int     = d_i[DW-1:FRAC];
    assign w_frac    = d_i[FRAC-1:0];
    assign w_int_inc = w_int + (DW-FRAC)'(1);

    // Exact integers pass through; anything with a fraction rounds up,
    // clamping at the largest integer instead of wrapping to zero.
    always_comb begin
        q_o = d_i;
        if (w_frac != '0) begin
            if (&w_int) begin
                q_o = SAT;
            end else begin
                q_o = {w_int_inc, {FRAC{1'b0}}};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maxpool_ceil.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : maxpool_ceil
// Brief    : Reads the 64x64 layer-0 image over the shared scratch bus,
//            applies 2x2 stride-2 max pooling with ceiling rounding and writes
//            the 32x32 result to layer-1 memory in raster order.
// Revision : 1.0  initial release
// ============================================================================
module maxpool_ceil
    import pool_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          csel
);

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [O_W-1:0] o_q, o_d;
    logic [DW-1:0]  max_q, max_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           crd_q, crd_d;
    logic           cwr_q, cwr_d;
    logic           csel_q, csel_d;
    logic [AW-1:0]  caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]  caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]  cdata_wr_q, cdata_wr_d;

    logic           w_sample;
    logic           w_first;
    logic [DW-1:0]  w_max_new;
    logic [DW-1:0]  w_ceil;

    // Read data of tap k-1 arrives while tap k is being issued; the last tap
    // lands in CAP. The first arriving tap reloads the running maximum so
    // nothing carries over from the previous window.
    assign w_sample  = ((state_q == RD) && (k_q != 2'd0)) || (state_q == CAP);
    assign w_first   = (state_q == RD) && (k_q == 2'd1);
    assign w_max_new = w_first             ? cdata_rd :
                       (cdata_rd > max_q)  ? cdata_rd : max_q;

    ceil_q_sat #(
        .DW   (DW),
        .FRAC (FRAC),
        .SAT  (SAT_VAL)
    ) u_ceil (
        .d_i (w_max_new),
        .q_o (w_ceil)
    );

    // Control state, window tap, output index and running maximum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            o_q     <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            o_q     <= o_d;
            max_q   <= max_d;
        end
    end

    // Next state plus next values of every registered bus output
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        o_d        = o_q;
        max_d      = w_sample ? w_max_new : max_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD;
                    k_d     = 2'd0;
                    o_d     = '0;
                end
            end
            RD: begin
                if (k_q == 2'd3) begin
                    state_d = CAP;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            CAP: begin
                state_d    = WR;
                caddr_wr_d = AW'(o_q);
                cdata_wr_d = w_ceil;
            end
            WR: begin
                if (o_q == O_LAST) begin
                    state_d = FIN;
                end else begin
                    state_d = RD;
                    k_d     = 2'd0;
                    o_d     = o_q + O_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == RD) || (state_d == CAP) || (state_d == WR);
        done_d     = (state_d == FIN);
        crd_d      = (state_d == RD);
        cwr_d      = (state_d == WR);
        csel_d     = (state_d == WR);
        caddr_rd_d = (state_d == RD) ? rd_addr(o_d, k_d) : caddr_rd_q;
    end

    // Registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_ceil.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_maxpool_ceil
// Brief    : Scoreboard bench for maxpool_ceil with behavioural layer-0 and
//            layer-1 memories on the shared scratch bus.
// Revision : 1.0  initial release
// ============================================================================
module tb_maxpool_ceil;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, crd, cwr, csel;
    logic [11:0] caddr_rd, caddr_wr;
    logic [12:0] cdata_rd, cdata_wr;

    always #5 clk = ~clk;

    maxpool_ceil dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    // Memories: synchronous read of layer-0, write strobe into layer-1
    logic [12:0] mem0 [4096];
    logic [12:0] mem1 [1024];

    always @(posedge clk) begin
        if (crd) cdata_rd <= mem0[caddr_rd];
        else     cdata_rd <= 'x;
        if (cwr && csel) mem1[caddr_wr[9:0]] <= cdata_wr;
    end

    typedef struct packed {
        logic [11:0] a;
        logic [12:0] d;
    } wr_t;

    wr_t         sb [$];
    wr_t         e_w;
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    logic [11:0] rd_log [4096];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every write against the scoreboard, logs reads
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (crd) begin
                if (rd_cnt < 4096) rd_log[rd_cnt] = caddr_rd;
                rd_cnt++;
            end
            if (crd && cwr) chk("crd_cwr_overlap", 1, 0);
            if (crd || cwr) chk("csel", {31'd0, csel}, {31'd0, cwr});
            if (cwr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {20'd0, caddr_wr}, 32'hFFFF_FFFF);
                end else begin
                    e_w = sb.pop_front();
                    chk("wr_addr", {20'd0, caddr_wr}, {20'd0, e_w.a});
                    chk("wr_data", {19'd0, cdata_wr}, {19'd0, e_w.d});
                end
            end
        end
    end

    // Hand-computed results for the directed windows; 13'h0010 elsewhere
    function automatic logic [12:0] exp_dir(input int o);
        case (o)
            0:       return 13'h0030;
            1:       return 13'h0040;
            2:       return 13'h0000;
            3:       return 13'h1FF0;
            4:       return 13'h0130;
            5:       return 13'h0010;
            33:      return 13'h1FF0;
            1023:    return 13'h1FF0;
            default: return 13'h0010;
        endcase
    endfunction

    task automatic set4(input int o, input logic [12:0] v0, v1, v2, v3);
        int base;
        base = (2 * (o / 32)) * 64 + 2 * (o % 32);
        mem0[base]      = v0;
        mem0[base + 1]  = v1;
        mem0[base + 64] = v2;
        mem0[base + 65] = v3;
    endtask

    task automatic fill_frame(input bit directed);
        for (int i = 0; i < 4096; i++) mem0[i] = 13'h0010;
        if (directed) begin
            set4(0,    13'h0021, 13'h0005, 13'h0030, 13'h002F);
            set4(1,    13'h0021, 13'h0005, 13'h0031, 13'h002F);
            set4(2,    13'h0000, 13'h0000, 13'h0000, 13'h0000);
            set4(3,    13'h0001, 13'h0002, 13'h0003, 13'h1FFF);
            set4(4,    13'h0123, 13'h0005, 13'h0100, 13'h0011);
            set4(5,    13'h0001, 13'h0001, 13'h0001, 13'h0001);
            set4(33,   13'h0010, 13'h1FF0, 13'h0000, 13'h0020);
            set4(1023, 13'h0007, 13'h1FF8, 13'h1000, 13'h0ABC);
        end
    endtask

    task automatic push_expected(input bit directed);
        wr_t e;
        for (int o = 0; o < 1024; o++) begin
            e.a = 12'(o);
            e.d = directed ? exp_dir(o) : 13'h0010;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input int repulse_at);
        int cnt;
        int d0;
        d0     = done_cnt;
        rd_cnt = 0;
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("crd_after_start", {31'd0, crd}, 1);
        chk("first_rd_addr", {20'd0, caddr_rd}, 0);
        cnt = 0;
        while (busy && cnt < 7000) begin
            cnt++;
            start = (cnt == repulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("busy_cycles", cnt, 6144);
        chk("done_at_busy_fall", {31'd0, done}, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("sb_drained", sb.size(), 0);
        chk("read_count", rd_cnt, 4096);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     {31'd0, busy}, 0);
        chk({tag, "_done"},     {31'd0, done}, 0);
        chk({tag, "_crd"},      {31'd0, crd}, 0);
        chk({tag, "_cwr"},      {31'd0, cwr}, 0);
        chk({tag, "_csel"},     {31'd0, csel}, 0);
        chk({tag, "_caddr_rd"}, {20'd0, caddr_rd}, 0);
        chk({tag, "_caddr_wr"}, {20'd0, caddr_wr}, 0);
        chk({tag, "_cdata_wr"}, {19'd0, cdata_wr}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  found;
        int  act;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(posedge clk); #2 reset = 1'b1;

        // Uniform 1.0 frame with an ignored start re-pulse mid-run
        fill_frame(1'b0);
        push_expected(1'b0);
        run_frame(100);
        chk("mem1_uniform_0", {19'd0, mem1[0]}, 32'h0010);
        chk("mem1_uniform_last", {19'd0, mem1[1023]}, 32'h0010);

        // Directed windows, rerun from o=0 after done
        fill_frame(1'b1);
        push_expected(1'b1);
        run_frame(0);
        chk("rd_o33_k0", {20'd0, rd_log[132]}, 32'h082);
        chk("rd_o33_k1", {20'd0, rd_log[133]}, 32'h083);
        chk("rd_o33_k2", {20'd0, rd_log[134]}, 32'h0C2);
        chk("rd_o33_k3", {20'd0, rd_log[135]}, 32'h0C3);
        chk("mem1_o0", {19'd0, mem1[0]}, 32'h0030);
        chk("mem1_o1023", {19'd0, mem1[1023]}, 32'h1FF0);

        // Asynchronous reset while output o=500 is in progress
        push_expected(1'b1);
        pulse_start();
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            if (cwr && caddr_wr == 12'd499) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reach_o500", found, 1);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        sb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        act = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || crd || cwr || done) act++;
        end
        chk("idle_after_reset", act, 0);

        // Fresh full frame after the aborted one
        push_expected(1'b1);
        run_frame(0);
        chk("mem1_after_reset_o4", {19'd0, mem1[4]}, 32'h0130);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
